// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding and default sizes for the register-file write arbiter.
package regfile_pkg;
  typedef enum logic {INIT, ARB} state_t;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_REGS = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; after a grant the pointer favours the other requester.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       ptr
);
  assign gnt[0] = req[0] & (~req[1] | ~ptr);
  assign gnt[1] = req[1] & (~req[0] | ptr);
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= 1'b0;
    else if (advance) ptr <= gnt[0];
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: clears registers 1..N-1 after reset, then round-robins two
// writers onto a single register-file write port with one cycle of latency.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValidA,
  output logic              ReqReadyA,
  input  logic [ADDR_W-1:0] ReqRegA,
  input  logic [DATA_W-1:0] ReqDataA,
  input  logic              ReqValidB,
  output logic              ReqReadyB,
  input  logic [ADDR_W-1:0] ReqRegB,
  input  logic [DATA_W-1:0] ReqDataB,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              InitDone,
  output logic              GrantB
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, wreg;
  logic [DATA_W-1:0] wdata;
  logic [1:0] gnt;
  logic ptr, last, hs, sel_b;
  rr_arbiter2 u_arb (
    .clk(Clk),
    .rst(Reset),
    .req({ReqValidB, ReqValidA}),
    .advance(hs),
    .gnt(gnt),
    .ptr(ptr)
  );
  assign last  = &cnt;
  assign hs    = ReqReadyA | ReqReadyB;
  // the pointer only decides when A is also pending
  assign sel_b = ptr ? ReqValidB : ~ReqValidA;
  assign wreg  = sel_b ? ReqRegB : ReqRegA;
  assign wdata = sel_b ? ReqDataB : ReqDataA;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= INIT;
    else state <= state_nxt;
  always_comb state_nxt = (state == INIT && last) ? ARB : state;
  always_comb begin
    ReqReadyA = (state == ARB) & ~Reset & gnt[0];
    ReqReadyB = (state == ARB) & ~Reset & gnt[1];
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      cnt <= '0;
      RegWrite <= 1'b0;
      WriteRegister <= '0;
      WriteData <= '0;
      GrantB <= 1'b0;
      InitDone <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      RegWrite <= ~last;
      InitDone <= last;
      if (!last) begin
        WriteRegister <= cnt + 1'b1;
        WriteData <= '0;
        GrantB <= 1'b0;
      end
    end else begin
      RegWrite <= hs & (wreg != '0);
      if (hs) begin
        WriteRegister <= wreg;
        WriteData <= wdata;
        GrantB <= sel_b;
      end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of the clear sequence, arbitration and reset behaviour.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  logic Clk = 0, Reset = 1;
  logic ReqValidA = 0, ReqValidB = 0, ReqReadyA, ReqReadyB;
  logic [4:0] ReqRegA = 0, ReqRegB = 0, WriteRegister;
  logic [31:0] ReqDataA = 0, ReqDataB = 0, WriteData;
  logic RegWrite, InitDone, GrantB;
  int checks = 0, failures = 0;
  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValidA(ReqValidA), .ReqReadyA(ReqReadyA), .ReqRegA(ReqRegA), .ReqDataA(ReqDataA),
    .ReqValidB(ReqValidB), .ReqReadyB(ReqReadyB), .ReqRegB(ReqRegB), .ReqDataB(ReqDataB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .InitDone(InitDone), .GrantB(GrantB)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic init_edge(input int k);
    tick();
    chk($sformatf("init_write_%0d", k), {RegWrite, ReqReadyA, ReqReadyB, InitDone, WriteRegister, WriteData},
        {1'b1, 3'b000, 5'(k), 32'd0});
  endtask
  task automatic wr(input string tag, input logic [4:0] r, input logic [31:0] d, input logic g);
    chk(tag, {RegWrite, WriteRegister, WriteData, GrantB}, {1'b1, r, d, g});
  endtask
  initial begin
    ReqValidA = 1; ReqValidB = 1; ReqRegA = 3; ReqRegB = 6; ReqDataA = 11; ReqDataB = 22;
    tick(); tick();
    chk("reset_state", {RegWrite, WriteRegister, WriteData, GrantB, InitDone, ReqReadyA, ReqReadyB}, '0);
    Reset = 0;
    for (int k = 1; k < NUM_REGS; k++) init_edge(k);
    tick();
    chk("init_done", {RegWrite, InitDone}, 2'b01);
    ReqValidA = 0; ReqValidB = 0;
    ReqValidA = 1; ReqRegA = 5; ReqDataA = 42;
    #1 chk("a_only_ready", {ReqReadyA, ReqReadyB}, 2'b10);
    tick(); ReqValidA = 0;
    wr("a_only_write", 5, 42, 0);
    tick();
    chk("idle_hold", {RegWrite, WriteRegister, WriteData, GrantB}, {1'b0, 5'd5, 32'd42, 1'b0});
    ReqValidB = 1; ReqRegB = 7; ReqDataB = 9;
    #1 chk("b_only_ready", {ReqReadyA, ReqReadyB}, 2'b01);
    tick(); ReqValidB = 0;
    wr("b_only_write", 7, 9, 1);
    ReqValidA = 1; ReqRegA = 2; ReqDataA = 15; ReqValidB = 1; ReqRegB = 4; ReqDataB = 42;
    #1 chk("both_ready_a", {ReqReadyA, ReqReadyB}, 2'b10);
    tick(); wr("alt_1_a", 2, 15, 0);
    chk("both_ready_b", {ReqReadyA, ReqReadyB}, 2'b01);
    tick(); wr("alt_2_b", 4, 42, 1);
    tick(); wr("alt_3_a", 2, 15, 0);
    tick(); wr("alt_4_b", 4, 42, 1);
    ReqValidA = 0; ReqValidB = 0;
    ReqValidB = 1; ReqRegB = 0; ReqDataB = 15;
    #1 chk("reg0_ready", {ReqReadyA, ReqReadyB}, 2'b01);
    tick(); ReqValidB = 0;
    chk("reg0_dropped", {30'd0, RegWrite}, 0);
    ReqValidA = 1; ReqRegA = 3; ReqValidB = 1; ReqRegB = 6;
    #1 chk("ptr_after_reg0", {ReqReadyA, ReqReadyB}, 2'b10);
    ReqValidB = 0; ReqRegA = 9; ReqDataA = 77;
    #6 Reset = 1;
    #1 chk("arb_reset_async", {RegWrite, InitDone, ReqReadyA, WriteRegister}, '0);
    tick(); Reset = 0; ReqValidA = 0;
    chk("arb_reset_no_write", {RegWrite, InitDone, WriteData}, '0);
    for (int k = 1; k <= 10; k++) init_edge(k);
    #2 Reset = 1;
    #1 chk("init_reset_async", {RegWrite, WriteRegister, InitDone, GrantB}, '0);
    #2 Reset = 0;
    for (int k = 1; k < NUM_REGS; k++) init_edge(k);
    tick();
    chk("reinit_done", {RegWrite, InitDone, ReqReadyA, ReqReadyB}, 4'b0100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
